// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the execute-stage branch resolver.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_RSV_2 = 3'b010;
    localparam logic [2:0] F3_RSV_3 = 3'b011;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;
    localparam logic [2:0] F3_BLTU  = 3'b110;
    localparam logic [2:0] F3_BGEU  = 3'b111;

endpackage

// File: rtl/branch_stat_ctr.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Latency: count visible the cycle after the increment edge; no backpressure.
module branch_stat_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Conditional-branch resolver: funct3 + ALU flags -> PC select, zero latency, no backpressure.
// Define BRANCH_UNIT_STATS_EN to add saturating branch/taken counters.
module branch_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       funct3,
    input  logic             alu_zero_i,
    input  logic             alu_result_lsb,
    input  logic             is_branch_op,
    output logic             branch_taken_o,
    output logic             illegal_br_o
`ifdef BRANCH_UNIT_STATS_EN
    ,
    input  logic             clr_stats_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
`endif
);

    always_comb begin
        branch_taken_o = 1'b0;
        illegal_br_o   = 1'b0;
        if (is_branch_op) begin
            case (funct3)
                F3_BEQ:   branch_taken_o = alu_zero_i;
                F3_BNE:   branch_taken_o = !alu_zero_i;
                F3_BLT:   branch_taken_o = alu_result_lsb;
                F3_BGE:   branch_taken_o = !alu_result_lsb;
                F3_BLTU:  branch_taken_o = alu_result_lsb;
                F3_BGEU:  branch_taken_o = !alu_result_lsb;
                F3_RSV_2,
                F3_RSV_3: illegal_br_o   = 1'b1;
                default:  branch_taken_o = 1'b0;
            endcase
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic br_inc;
    logic taken_inc;

    // Reserved encodings are not real branches, so they are not counted.
    assign br_inc    = is_branch_op && !illegal_br_o;
    assign taken_inc = br_inc && branch_taken_o;

    branch_stat_ctr #(.W(CNT_W)) u_br_ctr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_stats_i),
        .inc   (br_inc),
        .cnt   (br_cnt_o)
    );

    branch_stat_ctr #(.W(CNT_W)) u_taken_ctr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_stats_i),
        .inc   (taken_inc),
        .cnt   (taken_cnt_o)
    );
`else
    // Clock, reset and CNT_W are kept on the interface but have no function here.
    logic unused_sink;
    assign unused_sink = clk_i ^ rst_ni ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed and random checks of branch_unit; stats checks when BRANCH_UNIT_STATS_EN is defined.
module tb_branch_unit;

`ifdef BRANCH_UNIT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic             clk_i;
    logic             rst_ni;
    logic [2:0]       funct3;
    logic             alu_zero_i;
    logic             alu_result_lsb;
    logic             is_branch_op;
    logic             branch_taken_o;
    logic             illegal_br_o;
`ifdef BRANCH_UNIT_STATS_EN
    logic             clr_stats_i;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] taken_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    branch_unit #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .funct3         (funct3),
        .alu_zero_i     (alu_zero_i),
        .alu_result_lsb (alu_result_lsb),
        .is_branch_op   (is_branch_op),
        .branch_taken_o (branch_taken_o),
        .illegal_br_o   (illegal_br_o)
`ifdef BRANCH_UNIT_STATS_EN
        ,
        .clr_stats_i    (clr_stats_i),
        .br_cnt_o       (br_cnt_o),
        .taken_cnt_o    (taken_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic apply(input logic [2:0] f, input logic z, input logic l, input logic b);
        funct3         = f;
        alu_zero_i     = z;
        alu_result_lsb = l;
        is_branch_op   = b;
        #1;
    endtask

    // Reference: funct3[2] picks the flag, funct3[0] inverts it, 01x is reserved.
    function automatic logic ref_taken(input logic [2:0] f, input logic z, input logic l,
                                       input logic b);
        logic flag;
        if (!b || f[2:1] == 2'b01) return 1'b0;
        flag = f[2] ? l : z;
        return f[0] ? !flag : flag;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
`ifdef BRANCH_UNIT_STATS_EN
        clr_stats_i = 1'b0;
`endif
        apply(3'b000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (branch_taken_o !== 1'b0 || illegal_br_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: taken=%b illegal=%b required 0 0", branch_taken_o, illegal_br_o);
        end
`ifdef BRANCH_UNIT_STATS_EN
        n_cmp++;
        if (br_cnt_o !== '0 || taken_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_counters: br=%0d taken=%0d required 0 0", br_cnt_o, taken_cnt_o);
        end
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        // {funct3, zero, lsb, is_br, expected taken}
        logic [6:0] vec [12] = '{
            {3'b000, 1'b1, 1'b0, 1'b1, 1'b1},
            {3'b000, 1'b0, 1'b0, 1'b1, 1'b0},
            {3'b000, 1'b1, 1'b1, 1'b1, 1'b1},
            {3'b001, 1'b0, 1'b0, 1'b1, 1'b1},
            {3'b001, 1'b1, 1'b0, 1'b1, 1'b0},
            {3'b001, 1'b0, 1'b1, 1'b1, 1'b1},
            {3'b100, 1'b0, 1'b1, 1'b1, 1'b1},
            {3'b100, 1'b1, 1'b0, 1'b1, 1'b0},
            {3'b111, 1'b0, 1'b1, 1'b1, 1'b0},
            {3'b111, 1'b0, 1'b0, 1'b1, 1'b1},
            {3'b101, 1'b1, 1'b0, 1'b1, 1'b1},
            {3'b110, 1'b0, 1'b1, 1'b1, 1'b1}
        };
        for (int i = 0; i < 12; i++) begin
            apply(vec[i][6:4], vec[i][3], vec[i][2], vec[i][1]);
            n_cmp++;
            if (branch_taken_o !== vec[i][0] || illegal_br_o !== 1'b0) begin
                n_err++;
                $display("FAIL directed[%0d] f3=%b: taken=%b illegal=%b required %b 0",
                         i, vec[i][6:4], branch_taken_o, illegal_br_o, vec[i][0]);
            end
        end
    endtask

    task automatic test_gating();
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 4; fl++) begin
                apply(3'(f), fl[1], fl[0], 1'b0);
                n_cmp++;
                if (branch_taken_o !== 1'b0 || illegal_br_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL gating f3=%0d flags=%0d: taken=%b illegal=%b required 0 0",
                             f, fl, branch_taken_o, illegal_br_o);
                end
            end
        end
    endtask

    task automatic test_reserved();
        for (int fl = 0; fl < 4; fl++) begin
            apply(3'b010, fl[1], fl[0], 1'b1);
            n_cmp++;
            if (branch_taken_o !== 1'b0 || illegal_br_o !== 1'b1) begin
                n_err++;
                $display("FAIL reserved_010 flags=%0d: taken=%b illegal=%b required 0 1",
                         fl, branch_taken_o, illegal_br_o);
            end
            apply(3'b011, fl[1], fl[0], 1'b1);
            n_cmp++;
            if (branch_taken_o !== 1'b0 || illegal_br_o !== 1'b1) begin
                n_err++;
                $display("FAIL reserved_011 flags=%0d: taken=%b illegal=%b required 0 1",
                         fl, branch_taken_o, illegal_br_o);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] r;
        logic       exp_t;
        logic       exp_i;
        for (int i = 0; i < 200; i++) begin
            r = 6'($urandom_range(0, 63));
            apply(r[5:3], r[2], r[1], r[0]);
            exp_t = ref_taken(r[5:3], r[2], r[1], r[0]);
            exp_i = r[0] && (r[5:4] == 2'b01);
            n_cmp++;
            if (branch_taken_o !== exp_t || illegal_br_o !== exp_i) begin
                n_err++;
                $display("FAIL random[%0d] in=%b: taken=%b illegal=%b required %b %b",
                         i, r, branch_taken_o, illegal_br_o, exp_t, exp_i);
            end
        end
    endtask

`ifdef BRANCH_UNIT_STATS_EN
    task automatic drive_edge(input logic [2:0] f, input logic z, input logic l,
                              input logic b, input logic c);
        funct3         = f;
        alu_zero_i     = z;
        alu_result_lsb = l;
        is_branch_op   = b;
        clr_stats_i    = c;
        @(negedge clk_i);
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] eb,
                             input logic [CNT_W-1:0] et);
        n_cmp++;
        if (br_cnt_o !== eb || taken_cnt_o !== et) begin
            n_err++;
            $display("FAIL %s: br=%0d taken=%0d required %0d %0d", name, br_cnt_o, taken_cnt_o, eb, et);
        end
    endtask

    task automatic test_stats();
        @(negedge clk_i);
        drive_edge(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_edge(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("stats_start", 4'd0, 4'd0);
        drive_edge(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_edge(3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_edge(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_edge(3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_edge(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_cnt("stats_3br_2taken", 4'd3, 4'd2);
        drive_edge(3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_edge(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("stats_clear_priority", 4'd0, 4'd0);
        for (int i = 0; i < 15; i++) drive_edge(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_cnt("stats_all_ones", 4'hF, 4'hF);
        drive_edge(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_cnt("stats_saturate", 4'hF, 4'hF);
        drive_edge(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_edge(3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_edge(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        check_cnt("stats_after_clear", 4'd2, 4'd1);
        rst_ni = 1'b0;
        #1;
        check_cnt("stats_async_reset", 4'd0, 4'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive_edge(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_gating();
        test_reserved();
        test_random();
`ifdef BRANCH_UNIT_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
